// File: rtl/tnkiii_pkg.sv
// Purpose : shared timing constants, count types and parameter sanity check for TNK III video.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package tnkiii_pkg;

    localparam int CNT_W = 9;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   ext_t;   // one extra bit so an end bound of 512 does not wrap

    localparam int H_TOTAL_DEF  = 424;
    localparam int H_ACTIVE_DEF = 288;
    localparam int HS_START_DEF = 312;
    localparam int HS_WIDTH_DEF = 32;
    localparam int V_TOTAL_DEF  = 264;
    localparam int V_ACTIVE_DEF = 216;
    localparam int VS_START_DEF = 232;
    localparam int VS_WIDTH_DEF = 8;

    // One axis is legal when active <= sync start, sync end <= total, and total fits the counter.
    function automatic bit timing_ok(int active, int s_start, int s_width, int total);
        return (active <= s_start) && (s_start + s_width <= total) &&
               (total >= 1) && (total <= (1 << CNT_W));
    endfunction

endpackage

// File: rtl/tnkiii_wrap_counter.sv
// Purpose : modulo-N up counter with enable, exposing its next value and a wrap strobe.
// Latency : count updates on the enabled edge; o_count_nxt and o_wrap are combinational.
// Backpressure: none; holds whenever i_en is low.
module tnkiii_wrap_counter
    import tnkiii_pkg::*;
#(
    parameter int MODULUS = H_TOTAL_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_count_nxt,
    output logic             o_wrap
);

    localparam cnt_t LAST = cnt_t'(MODULUS - 1);

    cnt_t r_count;
    cnt_t w_count_nxt;
    logic w_at_last;

    // Next value: hold when idle, step or wrap to zero when enabled.
    always_comb begin
        w_at_last   = (r_count == LAST);
        w_count_nxt = r_count;
        if (i_en) begin
            w_count_nxt = w_at_last ? '0 : r_count + cnt_t'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_count     = r_count;
    assign o_count_nxt = w_count_nxt;
    assign o_wrap      = i_en & w_at_last;

endmodule

// File: rtl/tnkiii_video_timing.sv
// Purpose : TNK III raster timing: pixel/line counts, blanks, syncs, display enable, line/frame/irq strobes.
// Latency : all outputs registered; levels decoded from next counts so they line up with the counts.
// Backpressure: none; advances only on i_cen pixel enables, levels hold and strobes clear otherwise.
module tnkiii_video_timing
    import tnkiii_pkg::*;
#(
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int HS_START = HS_START_DEF,
    parameter int HS_WIDTH = HS_WIDTH_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int VS_START = VS_START_DEF,
    parameter int VS_WIDTH = VS_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_cen,
    output logic [CNT_W-1:0] o_hcount,
    output logic [CNT_W-1:0] o_vcount,
    output logic             o_hblank,
    output logic             o_vblank,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic             o_line_start,
    output logic             o_frame_start,
    output logic             o_vblank_irq
);

    // Illegal geometry stops elaboration instead of producing a silently broken raster.
    generate
        if (!timing_ok(H_ACTIVE, HS_START, HS_WIDTH, H_TOTAL)) begin : g_bad_h
            $error("tnkiii_video_timing: illegal horizontal timing parameters");
        end
        if (!timing_ok(V_ACTIVE, VS_START, VS_WIDTH, V_TOTAL)) begin : g_bad_v
            $error("tnkiii_video_timing: illegal vertical timing parameters");
        end
    endgenerate

    localparam cnt_t HA  = cnt_t'(H_ACTIVE);
    localparam cnt_t HSS = cnt_t'(HS_START);
    localparam ext_t HSE = ext_t'(HS_START + HS_WIDTH);
    localparam cnt_t VA  = cnt_t'(V_ACTIVE);
    localparam cnt_t VSS = cnt_t'(VS_START);
    localparam ext_t VSE = ext_t'(VS_START + VS_WIDTH);

    cnt_t w_hcount, w_h_nxt, w_vcount, w_v_nxt;
    logic w_h_wrap, w_v_wrap;
    logic w_hblank_nxt, w_vblank_nxt, w_hsync_nxt, w_vsync_nxt;
    logic r_hblank, r_vblank, r_hsync, r_vsync, r_de;
    logic r_line_start, r_frame_start, r_vblank_irq;

    // Pixel axis steps on each pixel enable; line axis steps on the pixel wrap.
    tnkiii_wrap_counter #(.MODULUS(H_TOTAL)) u_hcnt (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_en        (i_cen),
        .o_count     (w_hcount),
        .o_count_nxt (w_h_nxt),
        .o_wrap      (w_h_wrap)
    );

    tnkiii_wrap_counter #(.MODULUS(V_TOTAL)) u_vcnt (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_en        (w_h_wrap),
        .o_count     (w_vcount),
        .o_count_nxt (w_v_nxt),
        .o_wrap      (w_v_wrap)
    );

    // Decode levels from the counts about to be loaded so registered levels match registered counts.
    always_comb begin
        w_hblank_nxt = (w_h_nxt >= HA);
        w_vblank_nxt = (w_v_nxt >= VA);
        w_hsync_nxt  = (w_h_nxt >= HSS) && ({1'b0, w_h_nxt} < HSE);
        w_vsync_nxt  = (w_v_nxt >= VSS) && ({1'b0, w_v_nxt} < VSE);
    end

    // Level outputs: load only on pixel enables, hold in between.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hblank <= 1'b0;
            r_vblank <= 1'b0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_de     <= 1'b1;
        end else if (i_cen) begin
            r_hblank <= w_hblank_nxt;
            r_vblank <= w_vblank_nxt;
            r_hsync  <= w_hsync_nxt;
            r_vsync  <= w_vsync_nxt;
            r_de     <= ~w_hblank_nxt & ~w_vblank_nxt;
        end
    end

    // Strobes: set only on the wrapping pixel enable, cleared on every other edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_vblank_irq  <= 1'b0;
        end else begin
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
            r_vblank_irq  <= w_h_wrap & (w_v_nxt == VA);
        end
    end

    assign o_hcount      = w_hcount;
    assign o_vcount      = w_vcount;
    assign o_hblank      = r_hblank;
    assign o_vblank      = r_vblank;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_de          = r_de;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    assign o_vblank_irq  = r_vblank_irq;

endmodule

// File: tb/tb_tnkiii_video_timing.sv
// Purpose : self-checking bench for tnkiii_video_timing (default geometry plus a reduced-frame instance).
// Latency : outputs sampled 1 ns after each rising edge, inputs driven on the falling edge.
// Backpressure: n/a; i_cen is driven randomly, including back-to-back pulses.
`timescale 1ns/1ps
module tb_tnkiii_video_timing;

    typedef struct packed { int ht; int ha; int hss; int hsw; int vt; int va; int vss; int vsw; } tim_t;
    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic hb, vb, hs, vs, de, ls, fs, irq;
    } vt_t;

    localparam tim_t TD = '{ht:424, ha:288, hss:312, hsw:32, vt:264, va:216, vss:232, vsw:8};
    localparam tim_t TS = '{ht:40,  ha:24,  hss:28,  hsw:6,  vt:30,  va:20,  vss:22,  vsw:3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_d, cen_d, rst_n_s, cen_s;
    logic [8:0] hc_d, vc_d, hc_s, vc_s;
    logic hb_d, vb_d, hs_d, vs_d, de_d, ls_d, fs_d, irq_d;
    logic hb_s, vb_s, hs_s, vs_s, de_s, ls_s, fs_s, irq_s;
    vt_t obs_d, obs_s;

    assign obs_d = {hc_d, vc_d, hb_d, vb_d, hs_d, vs_d, de_d, ls_d, fs_d, irq_d};
    assign obs_s = {hc_s, vc_s, hb_s, vb_s, hs_s, vs_s, de_s, ls_s, fs_s, irq_s};

    tnkiii_video_timing dut_d (
        .i_clk(clk), .i_reset_n(rst_n_d), .i_cen(cen_d),
        .o_hcount(hc_d), .o_vcount(vc_d), .o_hblank(hb_d), .o_vblank(vb_d),
        .o_hsync(hs_d), .o_vsync(vs_d), .o_de(de_d),
        .o_line_start(ls_d), .o_frame_start(fs_d), .o_vblank_irq(irq_d)
    );

    tnkiii_video_timing #(
        .H_TOTAL(TS.ht), .H_ACTIVE(TS.ha), .HS_START(TS.hss), .HS_WIDTH(TS.hsw),
        .V_TOTAL(TS.vt), .V_ACTIVE(TS.va), .VS_START(TS.vss), .VS_WIDTH(TS.vsw)
    ) dut_s (
        .i_clk(clk), .i_reset_n(rst_n_s), .i_cen(cen_s),
        .o_hcount(hc_s), .o_vcount(vc_s), .o_hblank(hb_s), .o_vblank(vb_s),
        .o_hsync(hs_s), .o_vsync(vs_s), .o_de(de_s),
        .o_line_start(ls_s), .o_frame_start(fs_s), .o_vblank_irq(irq_s)
    );

    int errors = 0;
    int checks = 0;
    int n_d = 0, n_s = 0;        // pixel enables seen since the last reset release
    bit fired_d = 0, fired_s = 0; // a pixel enable landed on the most recent edge

    // Raster from first principles: n pixels after reset, pixel = n mod line, line = (n div line) mod frame.
    function automatic vt_t model(tim_t t, int n, bit fired);
        vt_t e;
        int  h, v;
        bit  at0;
        h     = n % t.ht;
        v     = (n / t.ht) % t.vt;
        e.h   = 9'(h);
        e.v   = 9'(v);
        e.hb  = (h >= t.ha);
        e.vb  = (v >= t.va);
        e.hs  = (h >= t.hss) && (h < t.hss + t.hsw);
        e.vs  = (v >= t.vss) && (v < t.vss + t.vsw);
        e.de  = !e.hb && !e.vb;
        at0   = fired && (n > 0) && (h == 0);
        e.ls  = at0;
        e.fs  = at0 && (v == 0);
        e.irq = at0 && (v == t.va);
        return e;
    endfunction

    task automatic tick_d(input bit cen);
        @(negedge clk);
        cen_d = cen;
        @(posedge clk);
        #1;
        fired_d = cen && rst_n_d;
        if (fired_d) n_d++;
    endtask

    task automatic tick_s(input bit cen);
        @(negedge clk);
        cen_s = cen;
        @(posedge clk);
        #1;
        fired_s = cen && rst_n_s;
        if (fired_s) n_s++;
    endtask

    task automatic test_reset();
        vt_t e;
        for (int i = 0; i < 6; i++) begin
            tick_d($urandom_range(0, 1) == 1);
            e = model(TD, 0, 0);
            checks++;
            if (obs_d !== e) begin
                errors++;
                $display("FAIL reset_hold: got h=%0d v=%0d f=%b, want h=%0d v=%0d f=%b",
                         obs_d.h, obs_d.v, obs_d[7:0], e.h, e.v, e[7:0]);
            end
        end
        @(negedge clk);
        rst_n_d = 1'b1;
        cen_d   = 1'b0;
        n_d     = 0;
        fired_d = 0;
        while (n_d < 10) begin
            tick_d($urandom_range(0, 2) != 0);
            e = model(TD, n_d, fired_d);
            checks++;
            if (obs_d !== e) begin
                errors++;
                $display("FAIL reset_run: got h=%0d v=%0d f=%b, want h=%0d v=%0d f=%b",
                         obs_d.h, obs_d.v, obs_d[7:0], e.h, e.v, e[7:0]);
            end
        end
        checks++;
        if (hc_d !== 9'd10 || vc_d !== 9'd0 || de_d !== 1'b1 || {ls_d, fs_d, irq_d} !== 3'b000) begin
            errors++;
            $display("FAIL reset_10_pulses: got h=%0d v=%0d de=%b strobes=%b, want h=10 v=0 de=1 strobes=000",
                     hc_d, vc_d, de_d, {ls_d, fs_d, irq_d});
        end
    endtask

    task automatic test_line_wrap();
        vt_t e;
        int  ls_cnt = 0;
        while (n_d < 424) begin
            tick_d($urandom_range(0, 2) != 0);
            e = model(TD, n_d, fired_d);
            checks++;
            if (obs_d !== e) begin
                errors++;
                $display("FAIL line_wrap_seq: got h=%0d v=%0d f=%b, want h=%0d v=%0d f=%b",
                         obs_d.h, obs_d.v, obs_d[7:0], e.h, e.v, e[7:0]);
            end
            if (ls_d) ls_cnt++;
        end
        checks++;
        if (hc_d !== 9'd0 || vc_d !== 9'd1) begin
            errors++;
            $display("FAIL line_wrap_pos: got h=%0d v=%0d, want h=0 v=1", hc_d, vc_d);
        end
        checks++;
        if (ls_cnt != 1) begin
            errors++;
            $display("FAIL line_start_count: got %0d, want 1", ls_cnt);
        end
    endtask

    task automatic test_hsync();
        vt_t e;
        int  hs_cnt = 0, hs_first = -1, hb_cnt = 0, hb_first = -1, hb_last = -1;
        while (n_d < 848) begin
            tick_d($urandom_range(0, 2) != 0);
            e = model(TD, n_d, fired_d);
            checks++;
            if (obs_d !== e) begin
                errors++;
                $display("FAIL hsync_seq: got h=%0d v=%0d f=%b, want h=%0d v=%0d f=%b",
                         obs_d.h, obs_d.v, obs_d[7:0], e.h, e.v, e[7:0]);
            end
            if (fired_d && hs_d) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(hc_d);
            end
            if (fired_d && hb_d) begin
                hb_cnt++;
                if (hb_first < 0) hb_first = int'(hc_d);
                hb_last = int'(hc_d);
            end
        end
        checks++;
        if (hs_cnt != 32 || hs_first != 312) begin
            errors++;
            $display("FAIL hsync_window: got width=%0d start=%0d, want width=32 start=312", hs_cnt, hs_first);
        end
        checks++;
        if (hb_cnt != 136 || hb_first != 288 || hb_last != 423) begin
            errors++;
            $display("FAIL hblank_window: got n=%0d first=%0d last=%0d, want n=136 first=288 last=423",
                     hb_cnt, hb_first, hb_last);
        end
    endtask

    task automatic test_cen_gating();
        vt_t e;
        int  strobes = 0;
        while (n_d < 848 + 150) begin
            tick_d($urandom_range(0, 2) != 0);
            e = model(TD, n_d, fired_d);
            checks++;
            if (obs_d !== e) begin
                errors++;
                $display("FAIL gating_lead: got h=%0d v=%0d f=%b, want h=%0d v=%0d f=%b",
                         obs_d.h, obs_d.v, obs_d[7:0], e.h, e.v, e[7:0]);
            end
        end
        for (int i = 0; i < 1000; i++) begin
            tick_d(1'b0);
            e = model(TD, n_d, 0);
            checks++;
            if (obs_d !== e) begin
                errors++;
                $display("FAIL gating_hold: cycle %0d got h=%0d v=%0d f=%b, want h=%0d v=%0d f=%b",
                         i, obs_d.h, obs_d.v, obs_d[7:0], e.h, e.v, e[7:0]);
            end
            if (ls_d || fs_d || irq_d) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL gating_strobes: got %0d strobe cycles, want 0", strobes);
        end
    endtask

    task automatic test_full_frame();
        vt_t e;
        int  fs_cnt = 0, irq_cnt = 0, irq_h = -1, irq_v = -1;
        int  vs_first = -1, vs_last = -1, vs_pix = 0, vs_bad = 0;
        logic prev_vs;
        @(negedge clk);
        rst_n_s = 1'b1;
        cen_s   = 1'b0;
        n_s     = 0;
        fired_s = 0;
        prev_vs = vs_s;
        while (n_s < TS.ht * TS.vt) begin
            tick_s($urandom_range(0, 2) != 0);
            e = model(TS, n_s, fired_s);
            checks++;
            if (obs_s !== e) begin
                errors++;
                $display("FAIL frame_seq: got h=%0d v=%0d f=%b, want h=%0d v=%0d f=%b",
                         obs_s.h, obs_s.v, obs_s[7:0], e.h, e.v, e[7:0]);
            end
            if (fs_s) fs_cnt++;
            if (irq_s) begin
                irq_cnt++;
                irq_h = int'(hc_s);
                irq_v = int'(vc_s);
            end
            if (fired_s && vs_s) begin
                vs_pix++;
                if (vs_first < 0) vs_first = int'(vc_s);
                vs_last = int'(vc_s);
            end
            if (vs_s !== prev_vs && hc_s !== 9'd0) vs_bad++;
            prev_vs = vs_s;
        end
        checks++;
        if (fs_cnt != 1 || hc_s !== 9'd0 || vc_s !== 9'd0) begin
            errors++;
            $display("FAIL frame_start: got count=%0d end h=%0d v=%0d, want count=1 h=0 v=0", fs_cnt, hc_s, vc_s);
        end
        checks++;
        if (irq_cnt != 1 || irq_v != TS.va || irq_h != 0) begin
            errors++;
            $display("FAIL vblank_irq: got count=%0d at h=%0d v=%0d, want count=1 at h=0 v=%0d",
                     irq_cnt, irq_h, irq_v, TS.va);
        end
        checks++;
        if (vs_first != 22 || vs_last != 24 || vs_pix != 3 * 40 || vs_bad != 0) begin
            errors++;
            $display("FAIL vsync_window: got lines %0d..%0d pixels=%0d midline_changes=%0d, want 22..24 120 0",
                     vs_first, vs_last, vs_pix, vs_bad);
        end
    endtask

    task automatic test_reset_midframe();
        vt_t e;
        int  fs_cnt = 0;
        int  target;
        target = n_s + 15 * TS.ht + 17;
        while (n_s < target) begin
            tick_s($urandom_range(0, 2) != 0);
            e = model(TS, n_s, fired_s);
            checks++;
            if (obs_s !== e) begin
                errors++;
                $display("FAIL midframe_lead: got h=%0d v=%0d f=%b, want h=%0d v=%0d f=%b",
                         obs_s.h, obs_s.v, obs_s[7:0], e.h, e.v, e[7:0]);
            end
        end
        // Assert reset between clock edges: outputs must clear without waiting for a clock.
        @(posedge clk);
        #3;
        rst_n_s = 1'b0;
        #1;
        e = model(TS, 0, 0);
        checks++;
        if (obs_s !== e) begin
            errors++;
            $display("FAIL async_reset: got h=%0d v=%0d f=%b, want h=%0d v=%0d f=%b",
                     obs_s.h, obs_s.v, obs_s[7:0], e.h, e.v, e[7:0]);
        end
        n_s     = 0;
        fired_s = 0;
        for (int i = 0; i < 3; i++) begin
            tick_s(1'b1);
            checks++;
            if (obs_s !== e || fired_s) begin
                errors++;
                $display("FAIL midframe_hold: got h=%0d v=%0d f=%b, want h=%0d v=%0d f=%b",
                         obs_s.h, obs_s.v, obs_s[7:0], e.h, e.v, e[7:0]);
            end
        end
        @(negedge clk);
        rst_n_s = 1'b1;
        cen_s   = 1'b0;
        while (n_s < TS.ht * TS.vt - 1) begin
            tick_s($urandom_range(0, 2) != 0);
            e = model(TS, n_s, fired_s);
            checks++;
            if (obs_s !== e) begin
                errors++;
                $display("FAIL post_reset_seq: got h=%0d v=%0d f=%b, want h=%0d v=%0d f=%b",
                         obs_s.h, obs_s.v, obs_s[7:0], e.h, e.v, e[7:0]);
            end
            if (fs_s) fs_cnt++;
        end
        checks++;
        if (fs_cnt != 0) begin
            errors++;
            $display("FAIL early_frame_start: got %0d before first full frame, want 0", fs_cnt);
        end
        tick_s(1'b1);
        checks++;
        if (fs_s !== 1'b1 || ls_s !== 1'b1 || hc_s !== 9'd0 || vc_s !== 9'd0) begin
            errors++;
            $display("FAIL first_frame_start: got fs=%b ls=%b h=%0d v=%0d, want fs=1 ls=1 h=0 v=0",
                     fs_s, ls_s, hc_s, vc_s);
        end
    endtask

    initial begin
        rst_n_d = 1'b0;
        cen_d   = 1'b0;
        rst_n_s = 1'b0;
        cen_s   = 1'b0;
        test_reset();
        test_line_wrap();
        test_hsync();
        test_cen_gating();
        test_full_frame();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tnkiii_video_timing.md
TNKIII_VIDEO_TIMING -- requirements
Module: tnkiii_video_timing

Interface
REQ-001 SHALL have parameter H_TOTAL, default 424: pixels per line (6.7 MHz / 424 = 15.80 kHz).
REQ-002 SHALL have parameter H_ACTIVE, default 288: visible pixels per line.
REQ-003 SHALL have parameter HS_START, default 312: first pixel at which o_hsync is high.
REQ-004 SHALL have parameter HS_WIDTH, default 32: o_hsync width in pixels.
REQ-005 SHALL have parameter V_TOTAL, default 264: lines per frame (59.86 Hz).
REQ-006 SHALL have parameter V_ACTIVE, default 216: visible lines.
REQ-007 SHALL have parameter VS_START, default 232, and VS_WIDTH, default 8: first line and width in lines of o_vsync.
REQ-008 SHALL have i_clk, input, 1: the 53.6 MHz core clock, the only clock in the block.
REQ-009 SHALL have i_reset_n, input, 1: reset, asynchronous, active-low.
REQ-010 SHALL have i_cen, input, 1: 6.7 MHz pixel clock enable, a single-i_clk pulse from the core clock-enable generator.
REQ-011 SHALL have o_hcount, output, 9: current pixel index.
REQ-012 SHALL have o_vcount, output, 9: current line index.
REQ-013 SHALL have o_hblank, o_vblank, o_hsync and o_vsync, outputs, 1 each, all active-high.
REQ-014 SHALL have o_de, output, 1: display enable, equal to ~o_hblank & ~o_vblank.
REQ-015 SHALL have o_line_start, o_frame_start and o_vblank_irq, outputs, 1 each: single-i_clk strobes.

Function
REQ-016 SHALL change state only on i_clk rising edges where i_cen=1; when i_cen=0, all counts and levels SHALL hold and all strobes SHALL be 0.
REQ-017 SHALL advance o_hcount by 1 on each i_cen; from H_TOTAL-1 it SHALL wrap to 0 and, on that same edge, advance o_vcount.
REQ-018 SHALL wrap o_vcount from V_TOTAL-1 to 0 on the line wrap.
REQ-019 SHALL register all level outputs (blank, sync, de) and decode them from the next-count values, so they are cycle-aligned with o_hcount/o_vcount and show no extra latency.
REQ-020 SHALL drive o_hblank=1 exactly when o_hcount>=H_ACTIVE.
REQ-021 SHALL drive o_vblank=1 exactly when o_vcount>=V_ACTIVE.
REQ-022 SHALL drive o_hsync=1 exactly when HS_START<=o_hcount<HS_START+HS_WIDTH.
REQ-023 SHALL drive o_vsync=1 exactly when VS_START<=o_vcount<VS_START+VS_WIDTH; vsync SHALL change only at line wrap.
REQ-024 SHALL pulse o_line_start for exactly one i_clk cycle, coincident with o_hcount becoming 0.
REQ-025 SHALL pulse o_frame_start for exactly one i_clk cycle when both counts become 0; o_line_start SHALL also pulse on that cycle.
REQ-026 SHALL pulse o_vblank_irq for exactly one i_clk cycle when o_vcount becomes V_ACTIVE with o_hcount=0; this strobe feeds the CPU interrupt latch.
REQ-027 SHALL keep counts in 9 bits; parameters SHALL satisfy H_ACTIVE<=HS_START, HS_START+HS_WIDTH<=H_TOTAL<=512, with the same rules for V; violating these SHALL trigger a simulation-only elaboration error.

Reset
REQ-028 SHALL, while i_reset_n=0 and irrespective of i_clk or i_cen, set o_hcount=0, o_vcount=0, all blanks=0, all syncs=0, o_de=1 and all strobes=0.
REQ-029 SHALL resume counting from 0,0 on the first i_cen after reset deasserts; reset asserted mid-frame SHALL abandon the frame with no strobe.
REQ-030 SHALL NOT issue o_frame_start for the post-reset 0,0 state; the first o_frame_start SHALL come at the first natural wrap.

Structure
REQ-031 SHALL take the default timing constants, and the 9-bit count type width, from the shared package tnkiii_pkg.
REQ-032 SHALL build both axes from one sub-module, tnkiii_wrap_counter (parameterised modulus, enable, wrap strobe), instantiated twice: H enabled by i_cen, V enabled by the H wrap strobe.

Verification
REQ-033 SHALL cover reset: release reset, then apply 10 i_cen pulses -> o_hcount=10, o_vcount=0, o_de=1, no strobes.
REQ-034 SHALL cover line wrap: 424 i_cen pulses from reset -> o_hcount=0, o_vcount=1, and one o_line_start pulse.
REQ-035 SHALL cover horizontal sync: o_hsync high for exactly 32 i_cen pulses starting at hcount 312, and o_hblank high for pixels 288..423.
REQ-036 SHALL cover a full frame: 111936 i_cen pulses -> one o_frame_start and one o_vblank_irq at vcount 216, and o_vsync high over lines 232..239.
REQ-037 SHALL cover i_cen gating: hold i_cen=0 for 1000 cycles mid-line -> all outputs frozen, no strobes.
REQ-038 SHALL cover reset mid-frame: assert i_reset_n=0 at vcount 100 -> immediate 0,0, and no o_frame_start after release until a full frame has elapsed.
